// File: rtl/execute_to_store_queue_pkg.sv
// ---------------------------------------------------------------------------
// execute_to_store_queue_pkg
// Shared CPU pipeline types used by the execute -> store hand-off, plus the
// default depth of the execute-to-store queue.
// Contents:
//   E2S_DEFAULT_DEPTH   default number of queue entries
//   memory_address_t    program counter / memory address
//   execution_mask_t    per-lane execution mask
//   RegisterID          destination register index
//   VectorValue         result payload
//   StorageStageOpcode  what the store stage does with the packet
//   ExecStageValue      result value plus destination register
//   ExecStagePacket     complete packet from execute to store
// ---------------------------------------------------------------------------
package execute_to_store_queue_pkg;

   localparam int E2S_DEFAULT_DEPTH = 4;

   typedef logic [31:0] memory_address_t;
   typedef logic [15:0] execution_mask_t;
   typedef logic [4:0]  RegisterID;
   typedef logic [31:0] VectorValue;

   typedef enum logic [1:0] {
      STORE_OP_NONE = 2'd0,
      STORE_OP_REG  = 2'd1,
      STORE_OP_MEM  = 2'd2,
      STORE_OP_PC   = 2'd3
   } StorageStageOpcode;

   typedef struct packed {
      VectorValue data;
      RegisterID  dest;
   } ExecStageValue;

   typedef struct packed {
      memory_address_t   PC;
      execution_mask_t   exec_mask;
      StorageStageOpcode opcode;
      logic              is_store_to_pc;
      ExecStageValue     value;
   } ExecStagePacket;

endpackage

// File: rtl/e2s_queue_mem.sv
// ---------------------------------------------------------------------------
// e2s_queue_mem
// DEPTH x ExecStagePacket register array, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset: occupancy is
// tracked by the pointers in the parent, so stale entries are never visible.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
// ---------------------------------------------------------------------------
module e2s_queue_mem
   import execute_to_store_queue_pkg::*;
#(
   parameter int DEPTH = E2S_DEFAULT_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           we,
   input  logic [AW-1:0]  waddr,
   input  ExecStagePacket wdata,
   input  logic [AW-1:0]  raddr,
   output ExecStagePacket rdata
);

   ExecStagePacket mem_r [DEPTH];

   // Write port: capture one packet per cycle when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/execute_to_store_queue.sv
// ---------------------------------------------------------------------------
// execute_to_store_queue
// Valid/ready circular queue of ExecStagePacket from execute to store, with
// flush-on-redirect, occupancy reporting and a sticky protocol-error flag.
// Optional feature macro: E2S_BYPASS_EN -- when defined, an empty queue
// forwards in_data straight to out_data in the same cycle if the consumer is
// ready (adds an in->out combinational path).
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     producer side (execute)
//   out_valid/out_ready/out_data  consumer side (store)
//   flush                   discard all queued packets (PC redirect)
//   count                   current occupancy
//   almost_full             count >= ALMOST_FULL_LEVEL
//   busy                    count != 0
//   protocol_err            sticky: push attempted while not ready
// ---------------------------------------------------------------------------
module execute_to_store_queue
   import execute_to_store_queue_pkg::*;
#(
   parameter int DEPTH             = E2S_DEFAULT_DEPTH,
   parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  ExecStagePacket           in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output ExecStagePacket           out_data,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full,
   output logic                     busy,
   output logic                     protocol_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
   localparam logic [PW-1:0] AF_CNT    = PW'(ALMOST_FULL_LEVEL);

   // Pointers carry one extra MSB so full (MSBs differ) and empty (equal)
   // are distinguishable; they wrap naturally modulo 2*DEPTH.
   logic [PW-1:0]  wr_ptr_r;
   logic [PW-1:0]  rd_ptr_r;
   logic [PW-1:0]  count_s;
   logic           full_s;
   logic           empty_s;
   logic           push_s;
   logic           pop_s;
   logic           bypass_s;
   logic           protocol_err_r;
   ExecStagePacket mem_rdata_s;

   assign count_s = wr_ptr_r - rd_ptr_r;
   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (count_s == DEPTH_CNT);

   // Bypass qualification: only an empty, unflushed queue with both sides
   // ready forwards directly.
   always_comb begin
      bypass_s = 1'b0;
`ifdef E2S_BYPASS_EN
      if (empty_s && !flush && in_valid && out_ready) begin
         bypass_s = 1'b1;
      end else begin
         bypass_s = 1'b0;
      end
`endif
   end

   // Handshake outputs and the internal push/pop strobes. in_ready never
   // looks at out_ready, so a full queue refuses a push even during a pop.
   always_comb begin
      in_ready  = !full_s && !flush && !reset;
      out_valid = (!empty_s && !flush) || bypass_s;
      if (bypass_s) begin
         out_data = in_data;
      end else begin
         out_data = mem_rdata_s;
      end
      // A bypassed packet is neither written nor popped from storage.
      push_s = in_valid && in_ready && !bypass_s;
      pop_s  = out_valid && out_ready && !bypass_s;
   end

   // Pointer update; flush outranks push and pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
      end else if (flush) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Sticky protocol error: a push offered while refused (a flush-dropped
   // packet is not an error). Only reset clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         protocol_err_r <= 1'b0;
      end else if (in_valid && !in_ready && !flush) begin
         protocol_err_r <= 1'b1;
      end
   end

   assign count        = count_s;
   assign busy         = !empty_s;
   assign almost_full  = (count_s >= AF_CNT);
   assign protocol_err = protocol_err_r;

   e2s_queue_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push_s),
      .waddr (wr_ptr_r[AW-1:0]),
      .wdata (in_data),
      .raddr (rd_ptr_r[AW-1:0]),
      .rdata (mem_rdata_s)
   );

endmodule

// File: tb/tb_execute_to_store_queue.sv
module tb_execute_to_store_queue;
   import execute_to_store_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int AF    = DEPTH - 1;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   ExecStagePacket in_data;
   logic           out_valid;
   logic           out_ready;
   ExecStagePacket out_data;
   logic           flush;
   logic [2:0]     count;
   logic           almost_full;
   logic           busy;
   logic           protocol_err;

   execute_to_store_queue #(.DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AF)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .flush        (flush),
      .count        (count),
      .almost_full  (almost_full),
      .busy         (busy),
      .protocol_err (protocol_err)
   );

   always #5 clk = ~clk;

   // Behavioural model: a plain queue of packets plus the sticky error bit.
   ExecStagePacket mq[$];
   ExecStagePacket outs[$];   // packets the consumer actually took
   logic           m_perr;
   int             total  = 0;
   int             passed = 0;

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   function automatic ExecStagePacket mk(logic [31:0] pc, logic [15:0] m);
      ExecStagePacket p;
      p.PC             = pc;
      p.exec_mask      = m;
      p.opcode         = STORE_OP_MEM;
      p.is_store_to_pc = pc[2];
      p.value.data     = ~pc;
      p.value.dest     = pc[6:2];
      return p;
   endfunction

   // One cycle: drive inputs, compare every output with the model, then
   // advance the model on the rising edge. Starts and ends on a falling edge.
   task automatic step(input logic v, input ExecStagePacket d, input logic rdy, input logic fl);
      int   n;
      logic m_inr, byp, m_ov;
      in_valid = v; in_data = d; out_ready = rdy; flush = fl;
      #1;
      n     = mq.size();
      m_inr = (n != DEPTH) && !fl;
      byp   = 1'b0;
`ifdef E2S_BYPASS_EN
      byp   = (n == 0) && !fl && v && rdy;
`endif
      m_ov  = ((n != 0) && !fl) || byp;
      chk("in_ready",     in_ready,     m_inr);
      chk("out_valid",    out_valid,    m_ov);
      chk("count",        count,        n);
      chk("busy",         busy,         n != 0);
      chk("almost_full",  almost_full,  n >= AF);
      chk("protocol_err", protocol_err, m_perr);
      if (m_ov) chk("out_data", out_data, byp ? d : mq[0]);
      @(posedge clk);
      if (v && !m_inr && !fl) m_perr = 1'b1;
      if (fl) mq.delete();
      else begin
         if (m_ov && rdy) begin
            if (byp) outs.push_back(d);
            else     outs.push_back(mq.pop_front());
         end
         if (v && m_inr && !byp) mq.push_back(d);
      end
      @(negedge clk);
   endtask

   ExecStagePacket idle_p;

   initial begin
      idle_p = mk(32'h0, 16'h0);
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = idle_p;
      m_perr = 1'b0;
      #1;
      chk("rst_in_ready",  in_ready,     1'b0);
      chk("rst_count",     count,        3'd0);
      chk("rst_out_valid", out_valid,    1'b0);
      chk("rst_busy",      busy,         1'b0);
      chk("rst_af",        almost_full,  1'b0);
      chk("rst_perr",      protocol_err, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      step(1'b0, idle_p, 1'b0, 1'b0);

      // Fill to DEPTH with consumer stalled, then drain in order.
      for (int i = 0; i < 4; i++) step(1'b1, mk(32'h10 + 32'(4*i), 16'h0), 1'b0, 1'b0);
      in_valid = 1'b0; #1;
      chk("full_count",    count,       3'd4);
      chk("full_in_ready", in_ready,    1'b0);
      chk("full_af",       almost_full, 1'b1);
      outs.delete();
      for (int i = 0; i < 4; i++) step(1'b0, idle_p, 1'b1, 1'b0);
      chk("drain_n", outs.size(), 4);
      for (int i = 0; i < 4; i++) chk("drain_pc", outs[i].PC, 32'h10 + 32'(4*i));

      // Two held, eight simultaneous push/pop cycles across pointer wrap.
      outs.delete();
      step(1'b1, mk(32'h100, 16'd1), 1'b0, 1'b0);
      step(1'b1, mk(32'h104, 16'd2), 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, mk(32'h108 + 32'(4*i), 16'(i + 3)), 1'b1, 1'b0);
      in_valid = 1'b0; out_ready = 1'b0; #1;
      chk("pp_count", count, 3'd2);
      step(1'b0, idle_p, 1'b1, 1'b0);
      step(1'b0, idle_p, 1'b1, 1'b0);
      chk("pp_n", outs.size(), 10);
      for (int i = 0; i < 10; i++) chk("pp_mask", outs[i].exec_mask, 16'(i + 1));

      // Flush with three queued and a concurrent push.
      outs.delete();
      for (int i = 0; i < 3; i++) step(1'b1, mk(32'h200 + 32'(4*i), 16'h0), 1'b0, 1'b0);
      step(1'b1, mk(32'hDEAD, 16'h0), 1'b0, 1'b1);
      in_valid = 1'b0; flush = 1'b0; #1;
      chk("fl_count", count,        3'd0);
      chk("fl_ov",    out_valid,    1'b0);
      chk("fl_perr",  protocol_err, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, idle_p, 1'b1, 1'b0);
      chk("fl_no_out", outs.size(), 0);

      // Push into a full queue: sticky error survives draining.
      for (int i = 0; i < 4; i++) step(1'b1, mk(32'h300 + 32'(4*i), 16'h0), 1'b0, 1'b0);
      step(1'b1, mk(32'h399, 16'h0), 1'b0, 1'b0);
      in_valid = 1'b0; #1;
      chk("perr_set", protocol_err, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, idle_p, 1'b1, 1'b0);
      chk("perr_sticky", protocol_err, 1'b1);

      // Asynchronous reset with two entries queued mid-transfer.
      step(1'b1, mk(32'h400, 16'h0), 1'b0, 1'b0);
      step(1'b1, mk(32'h404, 16'h0), 1'b0, 1'b0);
      in_valid = 1'b1; out_ready = 1'b1; in_data = mk(32'h408, 16'h0);
      #2 reset = 1'b1;
      #1;
      chk("arst_ov",    out_valid,    1'b0);
      chk("arst_count", count,        3'd0);
      chk("arst_inr",   in_ready,     1'b0);
      chk("arst_perr",  protocol_err, 1'b0);
      mq.delete(); m_perr = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      step(1'b0, idle_p, 1'b0, 1'b0);

      // Empty-queue latency with consumer ready.
      outs.delete();
      in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0; in_data = mk(32'h40, 16'h0);
      #1;
`ifdef E2S_BYPASS_EN
      chk("byp_ov", out_valid,   1'b1);
      chk("byp_pc", out_data.PC, 32'h40);
`else
      chk("lat_ov0", out_valid, 1'b0);
`endif
      step(1'b1, mk(32'h40, 16'h0), 1'b1, 1'b0);
      in_valid = 1'b0; out_ready = 1'b0; #1;
`ifdef E2S_BYPASS_EN
      chk("byp_count", count, 3'd0);
      chk("byp_taken", outs.size(), 1);
`else
      chk("lat_ov1", out_valid,   1'b1);
      chk("lat_pc",  out_data.PC, 32'h40);
`endif
      step(1'b0, idle_p, 1'b1, 1'b0);
      step(1'b0, idle_p, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/execute_to_store_queue.md
# execute_to_store_queue

Parametrised, multi-entry, valid/ready queue carrying `ExecStagePacket` from the execute stage to the store stage. It replaces the single-slot busy-flag channel, which had no backpressure and was only assertion-checked. It sits between execute (producer) and store (consumer), adds flush-on-redirect, occupancy reporting and a sticky protocol-error flag, and lets execute keep issuing while store stalls.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, ≥2.
- `ALMOST_FULL_LEVEL`, DEPTH-1, occupancy at or above which `almost_full` is asserted; range 1..DEPTH.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  execute presents a packet.
- `in_ready`  out  1  queue accepts a packet this cycle.
- `in_data`  in  $bits(ExecStagePacket)  packet from execute.
- `out_valid`  out  1  head packet available to store.
- `out_ready`  in  1  store consumes the head this cycle.
- `out_data`  out  $bits(ExecStagePacket)  head packet.
- `flush`  in  1  PC redirect; discard all queued packets.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `almost_full`  out  1  `count >= ALMOST_FULL_LEVEL`.
- `busy`  out  1  `count != 0`; equivalent of the old is_busy.
- `protocol_err`  out  1  sticky; set on push while `!in_ready`.

## Operation
- Circular buffer with read and write pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH.
- Push = `in_valid && in_ready`: write `in_data` at `wr_ptr`, increment `wr_ptr`.
- Pop = `out_valid && out_ready`: increment `rd_ptr`. `out_data` = entry at `rd_ptr`.
- `in_ready = !full && !flush && !reset`. It never depends on `out_ready`, so there is no combinational path from in to out. When full, push is refused even if a pop occurs in the same cycle.
- `out_valid = !empty && !flush`.
- Simultaneous push and pop when not full and not empty: `count` is unchanged and both pointers advance.
- Flush has priority over push and pop: both pointers are set to 0 and `count` becomes 0 the next cycle. A concurrent `in_valid` is dropped and is not an error.
- `protocol_err` is set when `in_valid && !in_ready && !flush`. It is cleared only by `reset`.
- `is_store_to_pc` packets get no special treatment. The redirect decision belongs to the consumer, which drives `flush` back.

## Timing
- Reset values: `count`=0, `busy`=0, `out_valid`=0, `almost_full`=0 (1 if `ALMOST_FULL_LEVEL`=0 is ever allowed; it is not), `protocol_err`=0, `in_ready`=0 while `reset` is high, and 1 from the first cycle after deassertion.
- Reset mid-operation: all entries are lost immediately (asynchronous). Storage contents are not cleared.
- Latency: a push at cycle N gives `out_valid` at N+1 (non-bypass build).
- Throughput: 1 packet per cycle sustained.
- `count`, `busy` and `almost_full` are registered-state derived and reflect pushes/pops of the previous edge.
- Full at DEPTH entries: `in_ready`=0 until the cycle after the first pop.

## Configuration
- `E2S_BYPASS_EN` defined:
  - When the queue is empty, `!flush`, `in_valid` and `out_ready` are all true, `in_data` drives `out_data` and `out_valid` combinationally in the same cycle.
  - Nothing is written and `count` stays 0.
  - This adds an in→out combinational path.
- Undefined: no bypass; minimum latency is 1 cycle, and `out_*` depend only on registered state.

## Structure
- `ExecStagePacket`, `ExecStageValue`, `StorageStageOpcode`, `execution_mask_t`, `memory_address_t`, `RegisterID` and `VectorValue` stay in the shared CPU types package. Add `E2S_DEFAULT_DEPTH` there.
- One sub-module, `e2s_queue_mem`: DEPTH×packet register array with one write port and one asynchronous read port. Pointer and flag logic stay in the top module.

## Test plan
- DEPTH=4: reset, push packets PC=0x10,0x14,0x18,0x1C with `out_ready`=0 → `count`=4, `in_ready`=0, `almost_full`=1. Then `out_ready`=1 → PCs emerge in order, one per cycle.
- Queue holds 2 entries; push and pop in the same cycle for 8 cycles → `count` stays 2, and the order of 8 distinct `exec_mask` values is preserved across pointer wrap.
- Queue holds 3 entries; assert `flush` with `in_valid`=1 → next cycle `count`=0, `out_valid`=0, dropped packet never appears, `protocol_err`=0.
- Full queue; drive `in_valid`=1 → `protocol_err`=1 and remains 1 after draining, until `reset`.
- Assert `reset` with 2 entries queued mid-transfer → `out_valid`=0 and `count`=0 immediately (before the next edge).
- With `E2S_BYPASS_EN`: empty queue, `in_valid`=`out_ready`=1, PC=0x40 → `out_valid`=1 and `out_data.PC`=0x40 in the same cycle, `count` stays 0. Without the macro → appears one cycle later.
